arpas_frame_collector: RTL

ARPAS_FRAME_COLLECTOR -- requirements
Module: arpas_frame_collector

---
 rtl/arpas_pkg.sv | 21 ++
 rtl/arpas_frame_collector_if.sv | 38 +++
 rtl/arpas_frame_collector_sync2.sv | 38 +++
 rtl/arpas_frame_collector.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arpas_pkg.sv
// ---------------------------------------------------------------------------
// arpas_pkg
// Shared types and constants for the ARPAS frame collector slice.
//   CW_DEFAULT : default per-channel count width in bits
//   N_CH       : number of demux channels collected per frame
//   chan_t     : 2-bit channel index carried alongside each output word
//   state_t    : collector FSM states (IDLE = buffer empty, SEND = frame held)
// ---------------------------------------------------------------------------
package arpas_pkg;

   localparam int CW_DEFAULT = 8;
   localparam int N_CH       = 4;

   typedef logic [1:0] chan_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/arpas_frame_collector_if.sv
// ---------------------------------------------------------------------------
// arpas_frame_collector_if
// Output word stream of the frame collector: one count word per channel,
// offered with a valid/ready handshake, plus the sticky overrun flag.
//   out_data  : count word (CW bits)
//   out_chan  : channel index of out_data
//   out_valid : word offered
//   out_ready : consumer accepts
//   overrun   : sticky, a completed frame was dropped
// master = the collector, slave = the consumer.
// ---------------------------------------------------------------------------
interface arpas_frame_collector_if #(
   parameter int CW = arpas_pkg::CW_DEFAULT
) ();

   logic [CW-1:0]   out_data;
   arpas_pkg::chan_t out_chan;
   logic            out_valid;
   logic            out_ready;
   logic            overrun;

   modport master (
      output out_data,
      output out_chan,
      output out_valid,
      output overrun,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_chan,
      input  out_valid,
      input  overrun,
      output out_ready
   );

endinterface

// File: rtl/arpas_frame_collector_sync2.sv
// ---------------------------------------------------------------------------
// arpas_sync2
// Plain two-flop synchronizer for a single asynchronous bit.
//   c : destination clock
//   r : asynchronous active-high reset (both stages cleared)
//   d : asynchronous input
//   q : synchronized output, two c edges after d settles
// Every input of the collector goes through an identical copy so that the
// step strobe and the channel bits keep the same latency.
// ---------------------------------------------------------------------------
module arpas_sync2 (
   input  logic c,
   input  logic r,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/arpas_frame_collector.sv
// ---------------------------------------------------------------------------
// arpas_frame_collector
// Counts, per demux channel, the c cycles that channel is high during one
// frame (four rising edges of the step strobe inc). At the end of a frame
// the four counts are copied into a buffer and streamed out as four words
// (channel 0..3) over a valid/ready handshake. A frame that completes while
// the previous one is still being sent is dropped and flagged in overrun.
//   c                     : clock
//   r                     : asynchronous active-high reset
//   inc                   : step strobe, asynchronous to c
//   ch00, ch01, ch10, ch11: demux outputs, asynchronous to c
//   out_data/out_chan     : offered word and its channel index
//   out_valid/out_ready   : output handshake
//   overrun               : sticky dropped-frame flag, cleared only by reset
// ---------------------------------------------------------------------------
module arpas_frame_collector
   import arpas_pkg::*;
#(
   parameter int CW = CW_DEFAULT
) (
   input  logic          c,
   input  logic          r,
   input  logic          inc,
   input  logic          ch00,
   input  logic          ch01,
   input  logic          ch10,
   input  logic          ch11,
   output logic [CW-1:0] out_data,
   output chan_t         out_chan,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          overrun
);

   logic        inc_s;
   logic [3:0]  ch_s;

   arpas_sync2 u_sync_inc  (.c(c), .r(r), .d(inc),  .q(inc_s));
   arpas_sync2 u_sync_ch00 (.c(c), .r(r), .d(ch00), .q(ch_s[0]));
   arpas_sync2 u_sync_ch01 (.c(c), .r(r), .d(ch01), .q(ch_s[1]));
   arpas_sync2 u_sync_ch10 (.c(c), .r(r), .d(ch10), .q(ch_s[2]));
   arpas_sync2 u_sync_ch11 (.c(c), .r(r), .d(ch11), .q(ch_s[3]));

   logic          inc_prev_q, inc_prev_d;
   logic          edge_q, edge_d;
   logic [1:0]    step_q, step_d;
   logic [CW-1:0] live_q [N_CH];
   logic [CW-1:0] live_d [N_CH];
   logic [CW-1:0] buf_q  [N_CH];
   logic [CW-1:0] buf_d  [N_CH];
   state_t        state_q, state_d;
   chan_t         k_q, k_d;
   logic          out_valid_q, out_valid_d;
   logic [CW-1:0] out_data_q, out_data_d;
   chan_t         out_chan_q, out_chan_d;
   logic          overrun_q, overrun_d;

   logic          frame_done;
   logic          handshake;
   logic          last_hs;

   // Next-state logic. The detected inc edge is registered once (edge_q),
   // which together with the two synchronizer stages and the output register
   // gives four c cycles from a settled inc edge to out_valid.
   always_comb begin
      inc_prev_d = inc_s;
      edge_d     = inc_s & ~inc_prev_q;

      frame_done = edge_q && (step_q == 2'd3);
      step_d     = edge_q ? step_q + 2'd1 : step_q;

      // On frame_done the counter restarts from this cycle's channel bit, so
      // the cycle that closes the frame belongs to the next frame.
      for (int i = 0; i < N_CH; i++) begin
         if (frame_done) begin
            live_d[i] = {{(CW-1){1'b0}}, ch_s[i]};
         end else if (ch_s[i] && (live_q[i] != {CW{1'b1}})) begin
            live_d[i] = live_q[i] + CW'(1);
         end else begin
            live_d[i] = live_q[i];
         end
      end

      handshake = (state_q == SEND) && out_ready;
      last_hs   = handshake && (k_q == 2'd3);

      state_d   = state_q;
      k_d       = k_q;
      buf_d     = buf_q;
      overrun_d = overrun_q;

      unique case (state_q)
         IDLE: begin
            if (frame_done) begin
               buf_d   = live_q;
               state_d = SEND;
               k_d     = 2'd0;
            end
         end
         SEND: begin
            if (handshake) begin
               k_d = k_q + 2'd1;
            end
            // A frame finishing exactly on the last handshake is taken
            // straight into the buffer instead of being dropped.
            if (last_hs) begin
               if (frame_done) begin
                  buf_d   = live_q;
                  state_d = SEND;
                  k_d     = 2'd0;
               end else begin
                  state_d = IDLE;
               end
            end else if (frame_done) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      out_valid_d = (state_d == SEND);
      out_data_d  = (state_d == SEND) ? buf_d[k_d] : '0;
      out_chan_d  = (state_d == SEND) ? k_d : 2'd0;
   end

   // All state, including the registered outputs, in one clocked block.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         inc_prev_q  <= 1'b0;
         edge_q      <= 1'b0;
         step_q      <= 2'd0;
         for (int i = 0; i < N_CH; i++) begin
            live_q[i] <= '0;
            buf_q[i]  <= '0;
         end
         state_q     <= IDLE;
         k_q         <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= 2'd0;
         overrun_q   <= 1'b0;
      end else begin
         inc_prev_q  <= inc_prev_d;
         edge_q      <= edge_d;
         step_q      <= step_d;
         live_q      <= live_d;
         buf_q       <= buf_d;
         state_q     <= state_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign overrun   = overrun_q;

endmodule
